// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit for the execute stage. Computes
// MULT/MULTU/DIV/DIVU in 32 clock cycles into the HI/LO registers.
// The unit works on operand magnitudes and applies the sign correction
// on the last iteration.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start, op     issue request (sampled when idle); 00 MULT, 01 MULTU,
//                 10 DIV, 11 DIVU
//   a, b          multiplicand/dividend, multiplier/divisor
//   mthi, mtlo    load wdata into HI and/or LO (idle and no start only)
//   wdata         data for mthi/mtlo
//   busy          operation in progress
//   done          one-cycle pulse when an operation writes HI/LO
//   hi, lo        HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic               is_div_reg;
  logic               div0_reg;
  logic               neg_res_reg;   // product / quotient sign
  logic               neg_rem_reg;   // remainder sign
  logic [WIDTH-1:0]   a_raw_reg;     // original dividend, for divide-by-zero HI
  // shift_reg supplies one bit per cycle from its MSB: the multiplier for
  // a multiply, the dividend for a divide. opnd_reg is the multiplicand
  // or the divisor.
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   opnd_reg;
  // Multiply: running product. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;

  // Operand preparation at start
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign sgn_a = ~op[0] & a[WIDTH-1];
  assign sgn_b = ~op[0] & b[WIDTH-1];
  assign abs_a = sgn_a ? -a : a;
  assign abs_b = sgn_b ? -b : b;

  // One iteration plus the final sign fix-up
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  always_comb begin
    rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], shift_reg[WIDTH-1]};
    diff     = rem_sh - {1'b0, opnd_reg};
    acc_next = '0;
    if (is_div_reg) begin
      // Restoring step: a borrow in diff means the divisor did not fit.
      if (!diff[WIDTH])
        acc_next = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      // MSB-first shift-add.
      acc_next = {acc_reg[2*WIDTH-2:0], 1'b0}
               + (shift_reg[WIDTH-1] ? {{WIDTH{1'b0}}, opnd_reg} : '0);
    end

    prod_neg = -acc_next;
    fin_hi   = '0;
    fin_lo   = '0;
    if (!is_div_reg) begin
      fin_hi = neg_res_reg ? prod_neg[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
      fin_lo = neg_res_reg ? prod_neg[WIDTH-1:0]       : acc_next[WIDTH-1:0];
    end else if (div0_reg) begin
      fin_hi = a_raw_reg;
      fin_lo = '1;
    end else begin
      // 0x80000000 / -1 yields 0x80000000 naturally: magnitude 2^31 negates to itself.
      fin_hi = neg_rem_reg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
      fin_lo = neg_res_reg ? -acc_next[WIDTH-1:0]       : acc_next[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      div0_reg    <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      a_raw_reg   <= '0;
      shift_reg   <= '0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            is_div_reg  <= op[1];
            div0_reg    <= (b == '0);
            neg_res_reg <= sgn_a ^ sgn_b;
            neg_rem_reg <= sgn_a;
            a_raw_reg   <= a;
            shift_reg   <= op[1] ? abs_a : abs_b;
            opnd_reg    <= op[1] ? abs_b : abs_a;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= CALC;
          end else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          cnt_reg   <= cnt_reg + CW'(1);
          if (&cnt_reg) begin
            hi_reg    <= fin_hi;
            lo_reg    <= fin_lo;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests    = 0;
  int failures = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion.
  // disturb: pulse start+mthi(0xAA) mid-calculation.
  // with_mtlo: assert mtlo(0x99) in the same cycle as start.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input bit disturb, input bit with_mtlo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo;
    int cycles;
    bit stable;
    @(negedge clk);
    old_hi = hi; old_lo = lo;
    op = o; a = x; b = y; start = 1'b1;
    if (with_mtlo) begin mtlo = 1'b1; wdata = 32'h99; end
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    if (with_mtlo) chk({tag, " lo_unchanged_by_mtlo"}, 64'(lo), 64'(old_lo));
    cycles = 0;
    stable = 1'b1;
    while (busy && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy && (hi !== old_hi || lo !== old_lo)) stable = 1'b0;
      if (disturb && cycles == 5) begin
        start = 1'b1; mthi = 1'b1; wdata = 32'hAA;
      end else if (disturb && cycles == 6) begin
        start = 1'b0; mthi = 1'b0;
      end
    end
    chk({tag, " cycles"}, 64'(cycles), 64'd32);
    chk({tag, " hilo_stable_in_calc"}, 64'(stable), 64'd1);
    chk({tag, " done_pulse"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
    $display("[TB] %s: op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", tag, o, x, y, hi, lo, cycles);
    @(negedge clk);
    chk({tag, " done_cleared"}, 64'(done), 64'd0);
    chk({tag, " busy_cleared"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    $display("[TB] reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    rst_n = 1'b1;

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_neg", MULTU, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, 32'h0000_0006, 32'hFFFF_FFEB);
    run_op("div_neg_disturb", DIV, 32'hFFFF_FFF9, 32'd2,     1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2",  DIVU,  32'd7,         32'd2,         1'b0, 1'b0, 32'd1,         32'd3);
    run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,         32'h8000_0000);
    run_op("divu_by0",  DIVU,  32'h0000_1234, 32'd0,         1'b0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_by0",   DIV,   32'hFFFF_FFF9, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // mthi + mtlo together in IDLE
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo hi", 64'(hi), 64'h55);
    chk("mthi_mtlo lo", 64'(lo), 64'h55);
    $display("[TB] mthi+mtlo: hi=%h lo=%h", hi, lo);

    // start wins over a same-cycle mtlo
    run_op("start_mtlo", DIVU, 32'd7, 32'd2, 1'b0, 1'b1, 32'd1, 32'd3);

    // Asynchronous reset in the middle of a MULTU
    @(negedge clk);
    op = MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    $display("[TB] mid-op reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_after_rst", MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the execute stage of the CPU. It sits beside the ALU and takes the same register-file operands `a`/`b`. It computes MULT/MULTU/DIV/DIVU over 32 clock cycles into the HI/LO registers. `busy` stalls the pipeline, and `hi`/`lo` feed the writeback mux next to the ALU `result`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the HI and LO registers are each `WIDTH` bits wide.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a new operation; sampled only when `busy`=0
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  WIDTH  operand a: multiplicand or dividend
- `b`  in  WIDTH  operand b: multiplier or divisor
- `mthi`  in  1  write `wdata` into HI
- `mtlo`  in  1  write `wdata` into LO
- `wdata`  in  WIDTH  data for `mthi`/`mtlo`
- `busy`  out  1  operation in progress; the pipeline stalls MFHI/MFLO and new mul/div ops
- `done`  out  1  one-cycle pulse when HI/LO are written by an operation
- `hi`  out  WIDTH  HI register: upper product half, or remainder
- `lo`  out  WIDTH  LO register: lower product half, or quotient

## Operation
- States: IDLE, CALC.
- IDLE:
  - `start`=1 latches `op`, |a|, |b| (absolute values for signed ops, raw values for unsigned ops) and the result signs.
  - Clears the 64-bit accumulator and the 5-bit counter, then goes to CALC.
- CALC: one iteration per cycle; the counter increments each cycle. At counter 31 the unit returns to IDLE.
- Multiply: radix-2 shift-add over the unsigned magnitudes.
  - Signed result is negated (64-bit two's complement) when sign(a)^sign(b)=1.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division over the unsigned magnitudes, one quotient bit per cycle.
  - Signed ops: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - LO = quotient, HI = remainder.
- Sign fix-up is combinational on the final iteration and is written to HI/LO together with the last step.
- Divide by zero (b==0, any op): still takes 32 cycles; LO=0xFFFFFFFF, HI=a (original, unsigned bit pattern).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap is raised.
- `mthi`/`mtlo`:
  - Honoured only when `busy`=0 and `start`=0; `start` wins a same-cycle conflict.
  - Both may assert together; both registers then load `wdata`.
  - Ignored while `busy`=1.
- `start` while `busy`=1 is ignored; no queuing.
- HI/LO hold their values between operations; they are never cleared except by reset.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter = 0.
- Reset mid-operation aborts the operation and discards the partial result. HI/LO return to 0.
- Latency: `start` sampled at edge k.
  - `busy`=1 from edge k.
  - Iterations occur at edges k+1 … k+32.
  - At edge k+32, HI/LO are written, `busy`→0 and `done`→1.
  - `done` returns to 0 at edge k+33.
- Throughput: the next `start` can be accepted at edge k+33, in the `done` cycle, giving back-to-back issue every 33 cycles.
- `hi`/`lo` change only at the final edge of an operation, or on an accepted `mthi`/`mtlo`. They are stable for the whole of CALC.
- `busy` and `done` are registered outputs with no combinational path from inputs.
- `a`, `b` and `op` may change after the `start` edge; the unit uses only the latched copies.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - `busy` is high for 32 cycles, then a single-cycle `done`.
  - HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7: HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
  - MULTU with the same operands gives HI=0x00000006, LO=0xFFFFFFEB.
- Signed division:
  - DIV a=−7, b=2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIVU a=7, b=2: LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero, DIVU a=0x1234, b=0: after 32 cycles LO=0xFFFFFFFF, HI=0x1234.
- Handshake:
  - Assert `start` again and `mthi` (wdata=0xAA) during CALC → both ignored; the result is unchanged.
  - In IDLE, `mthi`+`mtlo` with wdata=0x55 → HI=LO=0x55 next edge.
  - Same cycle `start`+`mtlo` → `mtlo` ignored and the operation starts.
- Pull `rst_n` low at iteration 15 of a MULTU:
  - `busy`, `done`, `hi` and `lo` go to 0 immediately.
  - After release, a new MULTU 3×5 gives LO=15, HI=0 at exactly 32 cycles.
